adam_aes_pipe_scheduler: RTL

// - Shares one fully pipelined AES-128 encipher core (1 block/cycle, fixed latency) between NUM_REQ requesters.
// - Round-robin arbitration feeds the core one block per cycle.
// - A tag pipeline follows each block's requester ID through the core.
// - A credit-guarded result FIFO returns ciphertext with its ID under valid/ready backpressure.
// - Sits between the peripheral request ports and the encipher core. Round keys are configured elsewhere; this block does not touch them.
//

---
 rtl/adam_aes_sched_pkg.sv | 21 ++
 rtl/adam_aes_sched_fifo.sv | 71 +++++++
 rtl/adam_aes_pipe_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/adam_aes_sched_pkg.sv
// Shared types and constants for the AES pipe scheduler.
// - aes_tag_t : {valid, id} record that travels beside each block through the core
// - aes_rsp_t : {id, data} record stored in the result FIFO
package adam_aes_sched_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned DEF_NUM_REQ = 4;
    // Requester ID width; the top's NUM_REQ must satisfy $clog2(NUM_REQ) == ID_W.
    localparam int unsigned ID_W        = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } aes_tag_t;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [AES_BLOCK_W-1:0] data;
    } aes_rsp_t;

endpackage

// File: rtl/adam_aes_sched_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   wr_valid_i/wr_data_i  push request and payload
//   rd_ready_i            pop request (ignored while empty)
//   rd_valid_o/rd_data_o  head entry; rd_data_o is zero while empty
// DEPTH need not be a power of two. A push into a full FIFO is only taken
// when a pop happens in the same cycle.
module adam_aes_sched_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wr_valid_i,
    input  T     wr_data_i,
    input  logic rd_ready_i,
    output logic rd_valid_o,
    output T     rd_data_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop  = rd_ready_i && (cnt_q != '0);
    assign push = wr_valid_i && ((cnt_q != CW'(DEPTH)) || pop);

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_valid_o = (cnt_q != '0);
    assign rd_data_o  = (cnt_q != '0) ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/adam_aes_pipe_scheduler.sv
// Shares one fully pipelined AES-128 encipher core between NUM_REQ requesters.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   enable                            allow new issues (draining always continues)
//   req_valid/req_ready/req_block     per-requester request channel (round-robin)
//   core_in_valid/core_in_block       block issued to the core
//   core_out_valid/core_out_block     core result, LATENCY cycles after issue
//   rsp_valid/rsp_ready/rsp_block/rsp_id  result channel with owning requester
//   busy                              work in flight or results pending
//   err                               sticky: core output disagreed with tag pipe
module adam_aes_pipe_scheduler
    import adam_aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned LATENCY    = 11,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  enable,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][AES_BLOCK_W-1:0]   req_block,
    output logic                                  core_in_valid,
    output logic [AES_BLOCK_W-1:0]                core_in_block,
    input  logic                                  core_out_valid,
    input  logic [AES_BLOCK_W-1:0]                core_out_block,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [AES_BLOCK_W-1:0]                rsp_block,
    output logic [ID_W-1:0]                       rsp_id,
    output logic                                  busy,
    output logic                                  err
);

    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   civ_q, civ_d;
    logic [AES_BLOCK_W-1:0] cib_q, cib_d;
    logic [ID_W-1:0]        issue_id_q, issue_id_d;
    aes_tag_t               tag_q [LATENCY];
    aes_tag_t               tag_d [LATENCY];
    aes_tag_t               tag_out;
    logic [CRED_W-1:0]      credits_q, credits_d;
    logic                   err_q, err_d;

    logic                   grant_any;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        idx;
    logic                   can_issue, accept, pop, tag_any;
    aes_rsp_t               fifo_wdata, fifo_rdata;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // Credits reserve a FIFO slot per accepted block, so the FIFO cannot overflow.
    assign can_issue = enable && reset_n && (credits_q != '0);
    assign accept    = grant_any && can_issue;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign pop       = rsp_valid && rsp_ready;
    assign tag_out   = tag_q[LATENCY-1];

    always_comb begin
        ptr_d      = accept ? grant_id : ptr_q;
        civ_d      = accept;
        cib_d      = accept ? req_block[grant_id] : cib_q;
        issue_id_d = accept ? grant_id : issue_id_q;

        // Tag enters from the issue register, so stage LATENCY-1 lines up
        // with the core output LATENCY cycles after core_in_valid.
        tag_d[0] = '{valid: civ_q, id: issue_id_q};
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (pop && !accept) begin
            credits_d = credits_q + CRED_W'(1);
        end

        err_d = err_q | (tag_out.valid ^ core_out_valid);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q      <= ID_W'(NUM_REQ - 1);
            civ_q      <= 1'b0;
            cib_q      <= '0;
            issue_id_q <= '0;
            tag_q      <= '{default: '0};
            credits_q  <= CRED_W'(FIFO_DEPTH);
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            civ_q      <= civ_d;
            cib_q      <= cib_d;
            issue_id_q <= issue_id_d;
            tag_q      <= tag_d;
            credits_q  <= credits_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_any = tag_any | tag_q[i].valid;
        end
    end

    // Only a valid tag writes; a spurious core_out_valid just raises err.
    assign fifo_wdata = '{id: tag_out.id, data: core_out_block};

    adam_aes_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (aes_rsp_t)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid_i (tag_out.valid),
        .wr_data_i  (fifo_wdata),
        .rd_ready_i (rsp_ready),
        .rd_valid_o (rsp_valid),
        .rd_data_o  (fifo_rdata)
    );

    assign core_in_valid = civ_q;
    assign core_in_block = cib_q;
    assign rsp_block     = fifo_rdata.data;
    assign rsp_id        = fifo_rdata.id;
    assign busy          = tag_any || civ_q || rsp_valid;
    assign err           = err_q;

endmodule
